// File: rtl/ldpc_fetch_pkg.sv
// ============================================================================
// ldpc_fetch_pkg : shared FSM encoding and default geometry for ldpc_fetch
// Rev 1.0
// ============================================================================
`default_nettype none

package ldpc_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RECV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int WID_DEF    = 6;
  localparam int CW_LEN_DEF = 9216;
  localparam int PACK_DEF   = 4;
  localparam int WDOG_DEF   = 1023;
  localparam int ADDR_W_DEF = $clog2(CW_LEN_DEF / PACK_DEF);

endpackage

`default_nettype wire

// File: rtl/ldpc_fetch_if.sv
// ============================================================================
// ldpc_fetch_if : deinterleaver-side and decoder-side signals of ldpc_fetch
// Rev 1.0
// ============================================================================
`default_nettype none

interface ldpc_fetch_if
  import ldpc_fetch_pkg::*;
#(
  parameter int WID  = WID_DEF,
  parameter int PACK = PACK_DEF,
  parameter int AW   = ADDR_W_DEF
);
  logic                bidin_rdy;
  logic                bidin_full;
  logic                bidin_ena_out;
  logic [WID-1:0]      bidin_dout;
  logic                dec_ready;
  logic                ldpc_req;
  logic                ldpc_fin;
  logic                dec_wr;
  logic [AW-1:0]       dec_addr;
  logic [WID*PACK-1:0] dec_data;
  logic                dec_start;
  logic                fetch_err;
  logic                ovf_warn;

  modport master (
    input  bidin_rdy, bidin_full, bidin_ena_out, bidin_dout, dec_ready,
    output ldpc_req, ldpc_fin, dec_wr, dec_addr, dec_data, dec_start,
           fetch_err, ovf_warn
  );

  modport slave (
    output bidin_rdy, bidin_full, bidin_ena_out, bidin_dout, dec_ready,
    input  ldpc_req, ldpc_fin, dec_wr, dec_addr, dec_data, dec_start,
           fetch_err, ovf_warn
  );
endinterface

`default_nettype wire

// File: rtl/ldpc_fetch_pack.sv
// ============================================================================
// ldpc_pack : packs accepted samples into decoder words, generates dec_wr/addr
// Rev 1.0
// ============================================================================
`default_nettype none

module ldpc_pack
  import ldpc_fetch_pkg::*;
#(
  parameter int WID  = WID_DEF,
  parameter int PACK = PACK_DEF,
  parameter int AW   = ADDR_W_DEF
) (
  input  wire logic                clk6,
  input  wire logic                rst_n,
  input  wire logic                clr_i,
  input  wire logic                acc_i,
  input  wire logic [WID-1:0]      din_i,
  output      logic                wr_o,
  output      logic [AW-1:0]       addr_o,
  output      logic [WID*PACK-1:0] data_o
);
  localparam int DW = WID * PACK;
  localparam int IW = (PACK > 1) ? $clog2(PACK) : 1;

  logic [DW-1:0] word_d;
  logic [DW-1:0] data_q;
  logic [IW-1:0] idx_q;
  logic [AW-1:0] addr_q;
  logic          wr_q;

  // Newest sample enters at the top, so the first sample ends up in the LSBs.
  if (PACK > 1) begin : g_multi
    logic [DW-WID-1:0] sh_q;

    always_ff @(posedge clk6 or negedge rst_n) begin
      if (!rst_n) begin
        sh_q <= '0;
      end else if (clr_i) begin
        sh_q <= '0;
      end else if (acc_i) begin
        sh_q <= word_d[DW-1:WID];
      end
    end

    assign word_d = {din_i, sh_q};
  end else begin : g_single
    assign word_d = din_i;
  end

  always_ff @(posedge clk6 or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (clr_i) begin
        idx_q  <= '0;
        addr_q <= '0;
      end else begin
        if (wr_q) begin
          addr_q <= addr_q + 1'b1;
        end
        if (acc_i) begin
          if (idx_q == IW'(PACK - 1)) begin
            idx_q  <= '0;
            data_q <= word_d;
            wr_q   <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
      end
    end
  end

  assign wr_o   = wr_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/ldpc_fetch.sv
// ============================================================================
// ldpc_fetch : requests codewords from the deinterleaver and fills decoder RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module ldpc_fetch
  import ldpc_fetch_pkg::*;
#(
  parameter int WID    = WID_DEF,
  parameter int CW_LEN = CW_LEN_DEF,
  parameter int PACK   = PACK_DEF,
  parameter int WDOG   = WDOG_DEF
) (
  input wire logic     clk6,
  input wire logic     rst_n,
  ldpc_fetch_if.master bus
);
  localparam int AW = $clog2(CW_LEN / PACK);
  localparam int CW = $clog2(CW_LEN);
  localparam int WW = $clog2(WDOG + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          accept;
  logic          timeout;
  logic          req_q, fin_q, start_q, err_q, ovf_q, full_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    accept  = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.bidin_rdy && bus.dec_ready) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_RECV;
        cnt_d   = '0;
        wd_d    = '0;
      end
      S_RECV: begin
        if (bus.bidin_ena_out) begin
          accept = 1'b1;
          wd_d   = '0;
          if (cnt_q == CW'(CW_LEN - 1)) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (wd_q == WW'(WDOG - 1)) begin
          // This idle cycle is the WDOG-th in a row: abandon the codeword.
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk6 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wd_q    <= '0;
      req_q   <= 1'b0;
      fin_q   <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      req_q   <= (state_d == S_REQ);
      fin_q   <= (state_q == S_DONE);
      start_q <= (state_q == S_DONE);
      err_q   <= timeout;
      full_q  <= bus.bidin_full;
      ovf_q   <= bus.bidin_full && !full_q && (state_q == S_IDLE);
    end
  end

  ldpc_pack #(
    .WID  (WID),
    .PACK (PACK),
    .AW   (AW)
  ) u_pack (
    .clk6   (clk6),
    .rst_n  (rst_n),
    .clr_i  (state_q == S_REQ),
    .acc_i  (accept),
    .din_i  (bus.bidin_dout),
    .wr_o   (bus.dec_wr),
    .addr_o (bus.dec_addr),
    .data_o (bus.dec_data)
  );

  assign bus.ldpc_req  = req_q;
  assign bus.ldpc_fin  = fin_q;
  assign bus.dec_start = start_q;
  assign bus.fetch_err = err_q;
  assign bus.ovf_warn  = ovf_q;

endmodule

`default_nettype wire
